// File: rtl/calc_pkg.sv
// Shared definitions for the calculator and the micro-coded multiply sequencer:
// opcodes, register indices, program length and the packed control word.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1001;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam logic SEL_IMM = 1'b0;
  localparam logic SEL_REG = 1'b1;

  localparam int         MULT_STEPS = 25;
  localparam logic [4:0] LAST_STEP  = 5'(MULT_STEPS - 1);

  typedef struct packed {
    logic       wen;
    logic [2:0] rw;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       sel;
    logic [3:0] ctrl;
    logic [7:0] datain;
  } ctrl_word_t;

  localparam ctrl_word_t IDLE_WORD = '{wen: 1'b0, rw: 3'd0, rx: 3'd0, ry: 3'd0,
                                       sel: 1'b0, ctrl: 4'b0000, datain: 8'h00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  function automatic ctrl_word_t make_cw(input logic       wen,
                                         input logic [2:0] rw,
                                         input logic [2:0] rx,
                                         input logic [2:0] ry,
                                         input logic       sel,
                                         input logic [3:0] ctrl,
                                         input logic [7:0] datain);
    ctrl_word_t cw;
    cw.wen    = wen;
    cw.rw     = rw;
    cw.rx     = rx;
    cw.ry     = ry;
    cw.sel    = sel;
    cw.ctrl   = ctrl;
    cw.datain = datain;
    return cw;
  endfunction

endpackage

// File: rtl/mult_ucode_rom.sv
// Combinational micro-code ROM: shift-and-add multiply program, one calculator
// operation per step. Bits of b become 0x00/0xFF masks in R3..R6, which gate a.
module mult_ucode_rom
  import calc_pkg::*;
(
  input  logic [4:0] step,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output ctrl_word_t cw
);

  logic [7:0] a_ext_s;
  logic [7:0] b_ext_s;

  assign a_ext_s = {4'b0000, a};
  assign b_ext_s = {4'b0000, b};

  // Program table lookup
  always_comb begin
    cw = IDLE_WORD;
    case (step)
      5'd0:  cw = make_cw(1'b1, R1, R0, R0, SEL_IMM, OP_ADD, a_ext_s);
      5'd1:  cw = make_cw(1'b1, R2, R0, R0, SEL_IMM, OP_ADD, b_ext_s);
      5'd2:  cw = make_cw(1'b1, R3, R0, R2, SEL_IMM, OP_AND, 8'd1);
      5'd3:  cw = make_cw(1'b1, R3, R0, R3, SEL_REG, OP_SUB, 8'd0);
      5'd4:  cw = make_cw(1'b1, R2, R2, R2, SEL_REG, OP_SRA, 8'd0);
      5'd5:  cw = make_cw(1'b1, R4, R0, R2, SEL_IMM, OP_AND, 8'd1);
      5'd6:  cw = make_cw(1'b1, R4, R0, R4, SEL_REG, OP_SUB, 8'd0);
      5'd7:  cw = make_cw(1'b1, R2, R2, R2, SEL_REG, OP_SRA, 8'd0);
      5'd8:  cw = make_cw(1'b1, R5, R0, R2, SEL_IMM, OP_AND, 8'd1);
      5'd9:  cw = make_cw(1'b1, R5, R0, R5, SEL_REG, OP_SUB, 8'd0);
      5'd10: cw = make_cw(1'b1, R2, R2, R2, SEL_REG, OP_SRA, 8'd0);
      5'd11: cw = make_cw(1'b1, R6, R0, R2, SEL_IMM, OP_AND, 8'd1);
      5'd12: cw = make_cw(1'b1, R6, R0, R6, SEL_REG, OP_SUB, 8'd0);
      5'd13: cw = make_cw(1'b1, R3, R1, R3, SEL_REG, OP_AND, 8'd0);
      5'd14: cw = make_cw(1'b1, R7, R0, R3, SEL_REG, OP_ADD, 8'd0);
      5'd15: cw = make_cw(1'b1, R4, R1, R4, SEL_REG, OP_AND, 8'd0);
      5'd16: cw = make_cw(1'b1, R4, R0, R4, SEL_IMM, OP_SLL, 8'd1);
      5'd17: cw = make_cw(1'b1, R7, R7, R4, SEL_REG, OP_ADD, 8'd0);
      5'd18: cw = make_cw(1'b1, R5, R1, R5, SEL_REG, OP_AND, 8'd0);
      5'd19: cw = make_cw(1'b1, R5, R0, R5, SEL_IMM, OP_SLL, 8'd2);
      5'd20: cw = make_cw(1'b1, R7, R7, R5, SEL_REG, OP_ADD, 8'd0);
      5'd21: cw = make_cw(1'b1, R6, R1, R6, SEL_REG, OP_AND, 8'd0);
      5'd22: cw = make_cw(1'b1, R6, R0, R6, SEL_IMM, OP_SLL, 8'd3);
      5'd23: cw = make_cw(1'b1, R7, R7, R6, SEL_REG, OP_ADD, 8'd0);
      // Read-back only: OR with R0 passes R7 onto busY without a write
      5'd24: cw = make_cw(1'b0, R0, R0, R7, SEL_REG, OP_OR,  8'd0);
      default: cw = IDLE_WORD;
    endcase
  end

endmodule

// File: rtl/mult_sequencer.sv
// FSM, step counter, operand latches and product register driving simple_calculator
// through the micro-code ROM; returns a 4x4 unsigned product with a done pulse.
module mult_sequencer
  import calc_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic       WEN,
  output logic [2:0] RW,
  output logic [2:0] RX,
  output logic [2:0] RY,
  output logic [7:0] DataIn,
  output logic       Sel,
  output logic [3:0] Ctrl,
  input  logic [7:0] busY
);

  mult_state_e state_r;
  mult_state_e state_s;
  logic [4:0]  step_r;
  logic [3:0]  a_r;
  logic [3:0]  b_r;
  logic        done_r;
  logic [7:0]  product_r;
  logic        accept_s;
  logic        last_step_s;
  ctrl_word_t  rom_cw_s;
  ctrl_word_t  cw_s;

  assign accept_s    = start && (state_r != ST_RUN);
  assign last_step_s = (state_r == ST_RUN) && (step_r == LAST_STEP);

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; DONE accepts a new start directly for back-to-back runs
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_RUN;
        else          state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_step_s) state_s = ST_DONE;
        else             state_s = ST_RUN;
      end
      ST_DONE: begin
        if (accept_s) state_s = ST_RUN;
        else          state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Step counter, operand latches, product capture and done pulse
  always_ff @(posedge Clk) begin
    if (Rst) begin
      step_r    <= 5'd0;
      a_r       <= 4'd0;
      b_r       <= 4'd0;
      done_r    <= 1'b0;
      product_r <= 8'd0;
    end else begin
      if ((state_r == ST_RUN) && !last_step_s) step_r <= step_r + 5'd1;
      else                                     step_r <= 5'd0;
      if (accept_s) begin
        a_r <= a;
        b_r <= b;
      end
      done_r <= last_step_s;
      if (last_step_s) product_r <= busY;
    end
  end

  mult_ucode_rom u_rom (
    .step (step_r),
    .a    (a_r),
    .b    (b_r),
    .cw   (rom_cw_s)
  );

  // Calculator drive: program word in RUN, idle word otherwise
  always_comb begin
    cw_s = IDLE_WORD;
    if (state_r == ST_RUN) cw_s = rom_cw_s;
    else                   cw_s = IDLE_WORD;
  end

  assign busy    = (state_r == ST_RUN);
  assign done    = done_r;
  assign product = product_r;
  assign WEN     = cw_s.wen;
  assign RW      = cw_s.rw;
  assign RX      = cw_s.rx;
  assign RY      = cw_s.ry;
  assign Sel     = cw_s.sel;
  assign Ctrl    = cw_s.ctrl;
  assign DataIn  = cw_s.datain;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench: mult_sequencer driving a behavioural simple_calculator model,
// checking results, latency, busy/done timing, reset and the control-word program.
module tb_mult_sequencer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic       WEN;
  logic [2:0] RW;
  logic [2:0] RX;
  logic [2:0] RY;
  logic [7:0] DataIn;
  logic       Sel;
  logic [3:0] Ctrl;
  logic [7:0] busY;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  creg [0:7];
  logic [7:0]  x_s;
  logic [7:0]  y_s;
  logic [22:0] exp_cw [0:24];

  mult_sequencer dut (
    .Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .WEN(WEN), .RW(RW), .RX(RX), .RY(RY), .DataIn(DataIn),
    .Sel(Sel), .Ctrl(Ctrl), .busY(busY)
  );

  always #5 Clk = ~Clk;

  // Calculator model: R0 reads zero, X from register or immediate, Y from register
  always_comb begin
    y_s = (RY == 3'd0) ? 8'h00 : creg[RY];
    if (Sel) x_s = (RX == 3'd0) ? 8'h00 : creg[RX];
    else     x_s = DataIn;
    case (Ctrl)
      4'b0000: busY = x_s + y_s;
      4'b0001: busY = x_s - y_s;
      4'b0010: busY = x_s & y_s;
      4'b0011: busY = x_s | y_s;
      4'b0111: busY = y_s << x_s[2:0];
      4'b1001: busY = {y_s[7], y_s[7:1]};
      default: busY = 8'h00;
    endcase
  end

  always @(posedge Clk) begin
    if (WEN && (RW != 3'd0)) creg[RW] <= busY;
  end

  function automatic logic [22:0] w(input logic wen, input logic [2:0] rw, rx, ry,
                                     input logic sel, input logic [3:0] ctrl,
                                     input logic [7:0] din);
    return {wen, rw, rx, ry, sel, ctrl, din};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " idle word"}, {9'd0, WEN, RW, RX, RY, Sel, Ctrl, DataIn}, 32'd0);
  endtask

  // One multiply; optional start poke or reset at a given step, optional cw table check
  task automatic run_mult(input logic [3:0] ta, input logic [3:0] tbv, input logic [7:0] expp,
                          input int poke_at, input int rst_at, input bit check_cw,
                          input string tag);
    int n;
    start = 1'b1; a = ta; b = tbv;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      if (check_cw && n < 25)
        chk($sformatf("%s cw step %0d", tag, n),
            {9'd0, WEN, RW, RX, RY, Sel, Ctrl, DataIn}, {9'd0, exp_cw[n]});
      if (n == rst_at) begin
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk({tag, " rst busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " rst done"}, {31'd0, done}, 32'd0);
        chk({tag, " rst product"}, {24'd0, product}, 32'd0);
        chk_idle({tag, " rst"});
        return;
      end
      if (n == poke_at) begin
        start = 1'b1; a = 4'hF; b = 4'hF;
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk({tag, " done seen"}, {31'd0, done}, 32'd1);
    chk({tag, " latency"}, n, 32'd25);
    chk({tag, " product"}, {24'd0, product}, {24'd0, expp});
    chk({tag, " busy in done"}, {31'd0, busy}, 32'd0);
    chk_idle({tag, " done"});
    tick();
    chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " product held"}, {24'd0, product}, {24'd0, expp});
  endtask

  initial begin
    int n;
    // Expected program for a=13, b=12 (immediates zero-extended)
    exp_cw[0]  = w(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 4'b0000, 8'h0D);
    exp_cw[1]  = w(1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 4'b0000, 8'h0C);
    exp_cw[2]  = w(1'b1, 3'd3, 3'd0, 3'd2, 1'b0, 4'b0010, 8'h01);
    exp_cw[3]  = w(1'b1, 3'd3, 3'd0, 3'd3, 1'b1, 4'b0001, 8'h00);
    exp_cw[4]  = w(1'b1, 3'd2, 3'd2, 3'd2, 1'b1, 4'b1001, 8'h00);
    exp_cw[5]  = w(1'b1, 3'd4, 3'd0, 3'd2, 1'b0, 4'b0010, 8'h01);
    exp_cw[6]  = w(1'b1, 3'd4, 3'd0, 3'd4, 1'b1, 4'b0001, 8'h00);
    exp_cw[7]  = w(1'b1, 3'd2, 3'd2, 3'd2, 1'b1, 4'b1001, 8'h00);
    exp_cw[8]  = w(1'b1, 3'd5, 3'd0, 3'd2, 1'b0, 4'b0010, 8'h01);
    exp_cw[9]  = w(1'b1, 3'd5, 3'd0, 3'd5, 1'b1, 4'b0001, 8'h00);
    exp_cw[10] = w(1'b1, 3'd2, 3'd2, 3'd2, 1'b1, 4'b1001, 8'h00);
    exp_cw[11] = w(1'b1, 3'd6, 3'd0, 3'd2, 1'b0, 4'b0010, 8'h01);
    exp_cw[12] = w(1'b1, 3'd6, 3'd0, 3'd6, 1'b1, 4'b0001, 8'h00);
    exp_cw[13] = w(1'b1, 3'd3, 3'd1, 3'd3, 1'b1, 4'b0010, 8'h00);
    exp_cw[14] = w(1'b1, 3'd7, 3'd0, 3'd3, 1'b1, 4'b0000, 8'h00);
    exp_cw[15] = w(1'b1, 3'd4, 3'd1, 3'd4, 1'b1, 4'b0010, 8'h00);
    exp_cw[16] = w(1'b1, 3'd4, 3'd0, 3'd4, 1'b0, 4'b0111, 8'h01);
    exp_cw[17] = w(1'b1, 3'd7, 3'd7, 3'd4, 1'b1, 4'b0000, 8'h00);
    exp_cw[18] = w(1'b1, 3'd5, 3'd1, 3'd5, 1'b1, 4'b0010, 8'h00);
    exp_cw[19] = w(1'b1, 3'd5, 3'd0, 3'd5, 1'b0, 4'b0111, 8'h02);
    exp_cw[20] = w(1'b1, 3'd7, 3'd7, 3'd5, 1'b1, 4'b0000, 8'h00);
    exp_cw[21] = w(1'b1, 3'd6, 3'd1, 3'd6, 1'b1, 4'b0010, 8'h00);
    exp_cw[22] = w(1'b1, 3'd6, 3'd0, 3'd6, 1'b0, 4'b0111, 8'h03);
    exp_cw[23] = w(1'b1, 3'd7, 3'd7, 3'd6, 1'b1, 4'b0000, 8'h00);
    exp_cw[24] = w(1'b0, 3'd0, 3'd0, 3'd7, 1'b1, 4'b0011, 8'h00);

    Rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset product", {24'd0, product}, 32'd0);
    chk_idle("reset");

    // Reset and start together: reset wins
    start = 1'b1; a = 4'd5; b = 4'd5;
    tick();
    chk("rst+start busy", {31'd0, busy}, 32'd0);
    Rst = 1'b0; start = 1'b0;
    tick();
    chk("idle no start busy", {31'd0, busy}, 32'd0);

    run_mult(4'd13, 4'd12, 8'd156, -1, -1, 1'b1, "13x12");
    run_mult(4'd15, 4'd15, 8'd225, -1, -1, 1'b0, "15x15");
    run_mult(4'd0,  4'd9,  8'd0,   -1, -1, 1'b0, "0x9");
    run_mult(4'd7,  4'd0,  8'd0,   -1, -1, 1'b0, "7x0");
    run_mult(4'd2,  4'd3,  8'd6,   10, -1, 1'b0, "2x3 poke");
    run_mult(4'd9,  4'd9,  8'd81,  -1, 12, 1'b0, "reset mid");
    tick();
    run_mult(4'd3,  4'd5,  8'd15,  -1, -1, 1'b0, "3x5");

    // start held high: back-to-back runs with no idle gap
    start = 1'b1; a = 4'd13; b = 4'd12;
    tick();
    n = 0;
    for (int r = 0; r < 3; r++) begin
      while (done !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk($sformatf("b2b run %0d done", r), {31'd0, done}, 32'd1);
      chk($sformatf("b2b run %0d latency", r), n, 32'd25);
      chk($sformatf("b2b run %0d product", r), {24'd0, product}, 32'd156);
      if (r < 2) begin
        tick();
        chk($sformatf("b2b run %0d restart busy", r), {31'd0, busy}, 32'd1);
        chk($sformatf("b2b run %0d restart done", r), {31'd0, done}, 32'd0);
        n = 0;
      end else begin
        start = 1'b0;
        tick();
        chk("b2b end busy", {31'd0, busy}, 32'd0);
        chk_idle("b2b end");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
